// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO in front of a UART register interface. For every queued byte the
//   sequencer reads the control register (to keep the rx-new flag), writes the
//   data register, writes the control register with the send bit set, then
//   polls until the UART clears the send bit.
//   Optional poll watchdog: define UART_FEED_TIMEOUT_EN to enable err_o.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | bus quiet; pops the FIFO head when one is available
//   S_RD_CTRL | control register selected for read; capture rx-new flag
//   S_WR_DATA | write the byte to the data register
//   S_WR_CTRL | write send=1 with the captured rx-new flag; arm guard counter
//   S_POLL    | wait out the guard, then wait for the UART to drop send
module uart_tx_feeder #(
  parameter int DEPTH          = 16,
  parameter int GUARD_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     flush_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     busy_o,
  output logic [15:0]              bytes_sent_o,
  output logic                     uart_wr_o,
  output logic                     uart_reg_sel_o,
  output logic [31:0]              uart_data_o,
  input  logic [31:0]              uart_rd_i,
  output logic                     err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);

  // Elaboration-time parameter sanity checks.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_feeder: DEPTH must be a power of two >= 2");
  end
  if (GUARD_CYCLES < 0 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
    $error("uart_tx_feeder: GUARD_CYCLES must be >= 0 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CTRL = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_CTRL = 3'd3,
    S_POLL    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     byte_q, byte_d;
  logic           rx_keep_q, rx_keep_d;
  logic [GW-1:0]  guard_q, guard_d;
  logic [15:0]    bytes_sent_q, bytes_sent_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     mem_q [DEPTH];
  logic           pop;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;

  // Only the send and rx-new bits of the control register are meaningful here.
  logic unused_rd_bits;
  assign unused_rd_bits = ^uart_rd_i[31:2];

`ifdef UART_FEED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`endif

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // A push at full is still taken when the FSM pops in the same cycle.
  assign push = push_i && (!fifo_full || pop);

  // FIFO pointer/occupancy update; flush overrides both push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care once pointers are cleared, so no reset.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      byte_q       <= '0;
      rx_keep_q    <= 1'b0;
      guard_q      <= '0;
      bytes_sent_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef UART_FEED_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      rx_keep_q    <= rx_keep_d;
      guard_q      <= guard_d;
      bytes_sent_q <= bytes_sent_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef UART_FEED_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  // Next-state and per-byte bookkeeping.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    rx_keep_d    = rx_keep_q;
    guard_d      = guard_q;
    bytes_sent_d = bytes_sent_q;
    pop          = 1'b0;
`ifdef UART_FEED_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          byte_d  = mem_q[rd_ptr_q];
          state_d = S_RD_CTRL;
        end
      end
      S_RD_CTRL: begin
        rx_keep_d = uart_rd_i[1];
        state_d   = S_WR_DATA;
      end
      S_WR_DATA: begin
        state_d = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        guard_d = GW'(GUARD_CYCLES);
`ifdef UART_FEED_TIMEOUT_EN
        wd_d    = '0;
`endif
        state_d = S_POLL;
      end
      S_POLL: begin
`ifdef UART_FEED_TIMEOUT_EN
        wd_d = wd_q + WDW'(1);
`endif
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (!uart_rd_i[0]) begin
          bytes_sent_d = bytes_sent_q + 16'd1;
          state_d      = S_IDLE;
        end
`ifdef UART_FEED_TIMEOUT_EN
        // A byte that completes on the watchdog's last cycle still counts as sent.
        if (state_d == S_POLL && wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_FEED_TIMEOUT_EN
    if (flush_i) err_d = 1'b0;
`endif
  end

  // Bus outputs decoded from the current state; reset forces them low at once.
  always_comb begin
    uart_wr_o      = 1'b0;
    uart_reg_sel_o = 1'b0;
    uart_data_o    = '0;
    busy_o         = (state_q != S_IDLE);
    case (state_q)
      S_WR_DATA: begin
        uart_wr_o      = 1'b1;
        uart_reg_sel_o = 1'b1;
        uart_data_o    = {24'h0, byte_q};
      end
      S_WR_CTRL: begin
        uart_wr_o   = 1'b1;
        uart_data_o = {30'h0, rx_keep_q, 1'b1};
      end
      default: ;
    endcase
  end

  assign full_o       = fifo_full;
  assign empty_o      = fifo_empty;
  assign count_o      = count_q;
  assign bytes_sent_o = bytes_sent_q;

`ifdef UART_FEED_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a small UART peripheral model, a byte scoreboard
// fed by the stimulus, and a monitor that checks every bus cycle.
module tb_uart_tx_feeder;

  localparam int DEPTH   = 16;
  localparam int GUARD   = 2;
  localparam int TIMEOUT = 50;

  logic        clk_i;
  logic        reset_i;
  logic        push_i;
  logic [7:0]  push_data_i;
  logic        flush_i;
  logic        full_o;
  logic        empty_o;
  logic [4:0]  count_o;
  logic        busy_o;
  logic [15:0] bytes_sent_o;
  logic        uart_wr_o;
  logic        uart_reg_sel_o;
  logic [31:0] uart_data_o;
  logic [31:0] uart_rd_i;
  logic        err_o;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];
  int         model_sent = 0;
  bit         expect_ctrl = 0;

  // UART peripheral model: mode 0 = clears send after frame_len cycles,
  // mode 1 = holds send high, mode 2 = never sets send.
  int   uart_mode = 0;
  int   frame_len = 20;
  int   frame_cnt;
  logic send_m;
  logic rx_flag = 1'b0;

  uart_tx_feeder #(
    .DEPTH          (DEPTH),
    .GUARD_CYCLES   (GUARD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .push_i         (push_i),
    .push_data_i    (push_data_i),
    .flush_i        (flush_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .count_o        (count_o),
    .busy_o         (busy_o),
    .bytes_sent_o   (bytes_sent_o),
    .uart_wr_o      (uart_wr_o),
    .uart_reg_sel_o (uart_reg_sel_o),
    .uart_data_o    (uart_data_o),
    .uart_rd_i      (uart_rd_i),
    .err_o          (err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Junk in the upper bits makes sure only bits [1:0] are used.
  assign uart_rd_i = uart_reg_sel_o ? 32'hDEAD_BEE0 : {30'h1555_5555, rx_flag, send_m};

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      send_m    <= 1'b0;
      frame_cnt <= 0;
    end else if (uart_wr_o && !uart_reg_sel_o) begin
      send_m    <= uart_data_o[0] && (uart_mode != 2);
      frame_cnt <= frame_len;
    end else if (send_m && uart_mode != 1) begin
      if (frame_cnt <= 1) send_m <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every bus cycle is either a data write matched against the
  // scoreboard, the control write that must follow it, or a quiet bus.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (uart_wr_o && uart_reg_sel_o) begin
        check("data_write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("data_byte", uart_data_o, {24'h0, exp_q.pop_front()});
        check("data_not_after_data", 32'(expect_ctrl), 32'd0);
        expect_ctrl = 1;
      end else if (expect_ctrl) begin
        check("ctrl_follows_data", {30'h0, uart_wr_o, uart_reg_sel_o}, 32'd2);
        check("ctrl_word", uart_data_o, {30'h0, rx_flag, 1'b1});
        expect_ctrl = 0;
      end else begin
        check("bus_quiet_wr", 32'(uart_wr_o), 32'd0);
        check("bus_quiet_data", uart_data_o, 32'd0);
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input bit accept);
    push_i      = 1'b1;
    push_data_i = d;
    if (accept) begin
      exp_q.push_back(d);
      model_sent++;
    end
    @(negedge clk_i);
    push_i = 1'b0;
  endtask

  task automatic wait_wr_ctrl();
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (uart_wr_o && !uart_reg_sel_o) begin
        seen = 1;
        break;
      end
    end
    check("wr_ctrl_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_drain(input int limit);
    bit done = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_i);
      if (!busy_o && empty_o) begin
        done = 1;
        break;
      end
    end
    check("drain_done", 32'(done), 32'd1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("bytes_sent", 32'(bytes_sent_o), 32'(model_sent & 16'hFFFF));
  endtask

  task automatic async_reset_and_check();
    #2 reset_i = 1'b1;
    exp_q.delete();
    expect_ctrl = 0;
    model_sent  = 0;
    #1;
    check("rst_wr", 32'(uart_wr_o), 32'd0);
    check("rst_data", uart_data_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_bytes", 32'(bytes_sent_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d;
    reset_i     = 1'b0;
    push_i      = 1'b0;
    push_data_i = 8'h00;
    flush_i     = 1'b0;
    #1 reset_i  = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_wr", 32'(uart_wr_o), 32'd0);
    check("reset_sel", 32'(uart_reg_sel_o), 32'd0);
    check("reset_data", uart_data_o, 32'd0);
    check("reset_empty", 32'(empty_o), 32'd1);
    check("reset_full", 32'(full_o), 32'd0);
    check("reset_count", 32'(count_o), 32'd0);
    check("reset_bytes", 32'(bytes_sent_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Single byte with exact bus timing.
    uart_mode = 0;
    frame_len = 20;
    push_byte(8'h41, 1);
    check("t1_idle_after_push", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    check("t1_rdctrl_busy", 32'(busy_o), 32'd1);
    check("t1_rdctrl_wr", {30'h0, uart_wr_o, uart_reg_sel_o}, 32'd0);
    @(negedge clk_i);
    check("t1_wrdata_bus", {30'h0, uart_wr_o, uart_reg_sel_o}, 32'd3);
    check("t1_wrdata_word", uart_data_o, 32'h0000_0041);
    @(negedge clk_i);
    check("t1_wrctrl_bus", {30'h0, uart_wr_o, uart_reg_sel_o}, 32'd2);
    check("t1_wrctrl_word", uart_data_o, 32'h0000_0001);
    wait_drain(200);
    check("t1_not_busy", 32'(busy_o), 32'd0);

    // rx-new flag preserved in the control write.
    rx_flag = 1'b1;
    frame_len = 5;
    push_byte(8'h55, 1);
    wait_wr_ctrl();
    check("t2_ctrl_rxkeep", uart_data_o, 32'h0000_0003);
    wait_drain(200);
    rx_flag = 1'b0;

    // Guard window: send never set, exit on third POLL cycle.
    uart_mode = 2;
    push_byte(8'h3C, 1);
    wait_wr_ctrl();
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    check("t3_poll3_busy", 32'(busy_o), 32'd1);
    check("t3_poll3_bytes", 32'(bytes_sent_o), 32'(model_sent - 1));
    @(negedge clk_i);
    check("t3_exit_busy", 32'(busy_o), 32'd0);
    check("t3_exit_bytes", 32'(bytes_sent_o), 32'(model_sent));

    // Overflow: FSM stuck on a prior byte, 17 pushes, last is dropped.
    uart_mode = 1;
    push_byte(8'hA5, 1);
    wait_wr_ctrl();
    for (int i = 0; i < 17; i++) begin
      push_byte(8'(i), i < DEPTH);
      if (i == DEPTH - 2) check("t4_not_full_15", 32'(full_o), 32'd0);
    end
    check("t4_full", 32'(full_o), 32'd1);
    check("t4_count", 32'(count_o), 32'(DEPTH));
    uart_mode = 0;
    frame_len = 3;
    wait_drain(3000);

    // Flush clears queued bytes (and wins over a same-cycle push), not the one in flight.
    uart_mode = 1;
    push_byte(8'h77, 1);
    wait_wr_ctrl();
    for (int i = 0; i < 4; i++) push_byte(8'hB0 + 8'(i), 1);
    check("t5_count_pre", 32'(count_o), 32'd4);
    flush_i     = 1'b1;
    push_i      = 1'b1;
    push_data_i = 8'hEE;
    model_sent -= exp_q.size();
    exp_q.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
    push_i  = 1'b0;
    check("t5_count", 32'(count_o), 32'd0);
    check("t5_empty", 32'(empty_o), 32'd1);
    check("t5_still_busy", 32'(busy_o), 32'd1);
    uart_mode = 0;
    wait_drain(300);

    // Randomized traffic with random frame times and rx-new flag changes.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) frame_len = $urandom_range(12, 1);
      if ($urandom_range(2) == 0 && exp_q.size() < DEPTH - 2) begin
        d = 8'($urandom);
        push_byte(d, 1);
      end else if (!busy_o && exp_q.size() == 0 && $urandom_range(9) == 0) begin
        rx_flag = ~rx_flag;
        @(negedge clk_i);
      end else begin
        @(negedge clk_i);
      end
    end
    wait_drain(3000);
    rx_flag = 1'b0;

`ifdef UART_FEED_TIMEOUT_EN
    // Watchdog: send held high, err after TIMEOUT poll cycles.
    uart_mode = 1;
    push_byte(8'h99, 1);
    wait_wr_ctrl();
    repeat (TIMEOUT) @(negedge clk_i);
    check("t6_err_before", 32'(err_o), 32'd0);
    check("t6_busy_before", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    model_sent--;
    check("t6_err_set", 32'(err_o), 32'd1);
    check("t6_idle", 32'(busy_o), 32'd0);
    check("t6_bytes", 32'(bytes_sent_o), 32'(model_sent & 16'hFFFF));
    repeat (3) @(negedge clk_i);
    check("t6_err_sticky", 32'(err_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check("t6_err_cleared", 32'(err_o), 32'd0);
    uart_mode = 0;
    wait_drain(100);
`else
    check("err_tied_low", 32'(err_o), 32'd0);
`endif

    // Reset during POLL with three bytes queued.
    uart_mode = 1;
    push_byte(8'h11, 1);
    wait_wr_ctrl();
    push_byte(8'h22, 1);
    push_byte(8'h33, 1);
    push_byte(8'h44, 1);
    check("t7_count_pre", 32'(count_o), 32'd3);
    async_reset_and_check();
    uart_mode = 0;
    repeat (30) @(negedge clk_i);
    check("t7_quiet_busy", 32'(busy_o), 32'd0);
    check("t7_quiet_bytes", 32'(bytes_sent_o), 32'd0);

    // Reset during WR_DATA drops uart_wr_o without a clock edge.
    push_byte(8'h5A, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("t8_wrdata_wr", 32'(uart_wr_o), 32'd1);
    async_reset_and_check();
    repeat (20) @(negedge clk_i);
    check("t8_quiet_busy", 32'(busy_o), 32'd0);
    check("t8_quiet_bytes", 32'(bytes_sent_o), 32'd0);
    check("final_err", 32'(err_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
